// File: rtl/riscv_pkg.sv
// Shared pipeline types: operand-forwarding select encoding and register address width.
package riscv_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FW_RF = 2'd0,
    FW_EX = 2'd1,
    FW_WB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: busy flag plus result-ready countdown for a single register.
module sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_alloc,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_clear,
  output logic             o_busy,
  output logic [LAT_W-1:0] o_cnt
);

  logic             r_busy;
  logic [LAT_W-1:0] r_cnt;

  // NOTE: state uses non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_alloc) begin
      // A new producer beats a same-cycle retirement of the old one.
      r_busy <= 1'b1;
      r_cnt  <= i_lat;
    end else if (i_clear) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: zero-latency stall and operand-forwarding decisions for Decode.
// Optional writeback bypass enabled by defining SCOREBOARD_WB_BYPASS_EN.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       iss_valid_D,
  input  logic                                       iss_reg_wr_D,
  input  logic [$clog2(NUM_REGS)-1:0]                iss_rd_D,
  input  logic [LAT_W-1:0]                           iss_lat_D,
  input  logic [NUM_SRC-1:0][$clog2(NUM_REGS)-1:0]   iss_rs_D,
  input  logic                                       flush_i,
  input  logic                                       wb_valid_W,
  input  logic [$clog2(NUM_REGS)-1:0]                wb_rd_W,
  output logic                                       stall_o,
  output logic [NUM_SRC-1:0][1:0]                    fwd_sel_o,
  output logic [31:0]                                stall_cnt_o
);

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0]            w_busy;
  logic [NUM_REGS-1:0][LAT_W-1:0] w_cnt;
  logic                           w_alloc;
  logic [NUM_SRC-1:0]             w_src_pend;
  logic                           w_wb_hit;
  logic [31:0]                    r_stall_cnt;

  assign w_alloc = iss_valid_D & ~stall_o & ~flush_i & iss_reg_wr_D;

  // x0 is hard-wired: never busy, so readers of it always take the register file.
  assign w_busy[0] = 1'b0;
  assign w_cnt[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_alloc (w_alloc && (iss_rd_D == AW'(r))),
      .i_lat   (iss_lat_D),
      .i_clear (wb_valid_W && (wb_rd_W == AW'(r))),
      .o_busy  (w_busy[r]),
      .o_cnt   (w_cnt[r])
    );
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_src_pend = '0;
    fwd_sel_o  = '0;
    w_wb_hit   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
      w_wb_hit = wb_valid_W && (wb_rd_W == iss_rs_D[k]);
`else
      w_wb_hit = 1'b0;
`endif
      if (iss_rs_D[k] != '0 && w_busy[iss_rs_D[k]]) begin
        if (w_wb_hit) begin
          fwd_sel_o[k] = FW_WB;
        end else if (w_cnt[iss_rs_D[k]] == '0) begin
          fwd_sel_o[k] = FW_EX;
        end else begin
          w_src_pend[k] = 1'b1;
        end
      end
    end
  end

  assign stall_o = iss_valid_D & ~flush_i & (|w_src_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule
